// File: rtl/spi_reg_slave_if.sv
// Signal bundle between the SPI responder and its environment: the four-wire
// SPI link, the local register port and the frame status outputs.
interface spi_reg_slave_if;
  logic       sck;
  logic       ss;
  logic       mosi;
  logic       miso;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       frame_done;
  logic       frame_err;

  modport slave (
    input  sck, ss, mosi, reg_rdata,
    output miso, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done, frame_err
  );

  // Environment view: the SPI master plus the register bank behind the port.
  modport master (
    output sck, ss, mosi, reg_rdata,
    input  miso, reg_addr, reg_wdata, reg_we, reg_re, busy, frame_done, frame_err
  );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 responder: decodes a read/write command byte and streams data
// bytes to or from a registered-read register port, with optional auto-increment.
module spi_reg_slave #(
  parameter bit AUTO_INC = 1'b1
) (
  input logic            clk,
  input logic            rst,
  spi_reg_slave_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  // The synchronizer chains carry no reset so that releasing reset while ss is
  // already low can never fabricate a falling edge.
  logic sck_meta_reg, sck_sync_reg, sck_prev_reg;
  logic ss_meta_reg, ss_sync_reg, ss_prev_reg;
  logic mosi_meta_reg, mosi_sync_reg;

  always_ff @(posedge clk) begin
    sck_meta_reg  <= bus.sck;
    sck_sync_reg  <= sck_meta_reg;
    sck_prev_reg  <= sck_sync_reg;
    ss_meta_reg   <= bus.ss;
    ss_sync_reg   <= ss_meta_reg;
    ss_prev_reg   <= ss_sync_reg;
    mosi_meta_reg <= bus.mosi;
    mosi_sync_reg <= mosi_meta_reg;
  end

  logic sck_rise, sck_fall, ss_rise, ss_fall;
  assign sck_rise = sck_sync_reg & ~sck_prev_reg;
  assign sck_fall = ~sck_sync_reg & sck_prev_reg;
  assign ss_rise  = ss_sync_reg & ~ss_prev_reg;
  assign ss_fall  = ~ss_sync_reg & ss_prev_reg;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [6:0] rx_shift_reg, rx_shift_next;
  logic [7:0] tx_shift_reg, tx_shift_next;
  logic [6:0] addr_reg, addr_next;
  logic [6:0] reg_addr_reg, reg_addr_next;
  logic [7:0] reg_wdata_reg, reg_wdata_next;
  logic       reg_we_reg, reg_we_next;
  logic       reg_re_reg, reg_re_next;
  logic       re_dly_reg;
  logic       busy_reg, busy_next;
  logic       frame_done_reg, frame_done_next;
  logic       frame_err_reg, frame_err_next;
  logic       miso_reg, miso_next;

  logic [7:0] rx_byte;
  logic [6:0] addr_step;
  logic       byte_done;

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    rx_shift_next   = rx_shift_reg;
    tx_shift_next   = tx_shift_reg;
    addr_next       = addr_reg;
    reg_addr_next   = reg_addr_reg;
    reg_wdata_next  = reg_wdata_reg;
    reg_we_next     = 1'b0;
    reg_re_next     = 1'b0;
    frame_done_next = 1'b0;
    frame_err_next  = 1'b0;
    byte_done       = 1'b0;
    rx_byte         = {rx_shift_reg, mosi_sync_reg};
    addr_step       = AUTO_INC ? addr_reg + 7'd1 : addr_reg;

    if (state_reg != IDLE) begin
      // The falling edge that follows a byte boundary must not shift, or the
      // freshly loaded MSB would be lost before the master samples it.
      if (state_reg == RDATA && sck_fall && bit_cnt_reg != 3'd0)
        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
      if (sck_rise) begin
        bit_cnt_next  = bit_cnt_reg + 3'd1;
        rx_shift_next = rx_byte[6:0];
        byte_done     = (bit_cnt_reg == 3'd7);
      end
    end

    // Read data returns one clk after the request; load it into the shifter.
    if (re_dly_reg)
      tx_shift_next = bus.reg_rdata;

    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next   = CMD;
          bit_cnt_next = 3'd0;
        end
      end
      CMD: begin
        if (byte_done) begin
          addr_next = rx_byte[6:0];
          if (rx_byte[7]) begin
            state_next    = RDATA;
            reg_re_next   = 1'b1;
            reg_addr_next = rx_byte[6:0];
          end else begin
            state_next = WDATA;
          end
        end
      end
      WDATA: begin
        if (byte_done) begin
          reg_we_next    = 1'b1;
          reg_addr_next  = addr_reg;
          reg_wdata_next = rx_byte;
          addr_next      = addr_step;
        end
      end
      RDATA: begin
        // Prefetch the next location so it is ready for the following byte.
        if (byte_done) begin
          reg_re_next   = 1'b1;
          reg_addr_next = addr_step;
          addr_next     = addr_step;
        end
      end
      default: state_next = IDLE;
    endcase

    // Frame close wins over the state logic but keeps any byte completed in
    // the same clk, so that byte still counts as whole.
    if (state_reg != IDLE && ss_rise) begin
      state_next   = IDLE;
      bit_cnt_next = 3'd0;
      if (bit_cnt_reg == 3'd0 || byte_done)
        frame_done_next = 1'b1;
      else
        frame_err_next = 1'b1;
    end

    busy_next = (state_next != IDLE);
    miso_next = (state_next == RDATA) ? tx_shift_next[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= 3'd0;
      rx_shift_reg   <= 7'd0;
      tx_shift_reg   <= 8'd0;
      addr_reg       <= 7'd0;
      reg_addr_reg   <= 7'd0;
      reg_wdata_reg  <= 8'd0;
      reg_we_reg     <= 1'b0;
      reg_re_reg     <= 1'b0;
      re_dly_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      miso_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      rx_shift_reg   <= rx_shift_next;
      tx_shift_reg   <= tx_shift_next;
      addr_reg       <= addr_next;
      reg_addr_reg   <= reg_addr_next;
      reg_wdata_reg  <= reg_wdata_next;
      reg_we_reg     <= reg_we_next;
      reg_re_reg     <= reg_re_next;
      re_dly_reg     <= reg_re_reg;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      frame_err_reg  <= frame_err_next;
      miso_reg       <= miso_next;
    end
  end

  assign bus.miso       = miso_reg;
  assign bus.reg_addr   = reg_addr_reg;
  assign bus.reg_wdata  = reg_wdata_reg;
  assign bus.reg_we     = reg_we_reg;
  assign bus.reg_re     = reg_re_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.frame_err  = frame_err_reg;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: one auto-increment and one fixed-address instance
// share the SPI stimulus; a frame-level model predicts strobes and read bytes.
module tb_spi_reg_slave;
  localparam int H = 6;  // SPI half period in clk cycles

  logic clk, rst;
  logic sck, ss, mosi;
  int   tests = 0, fails = 0, cyc = 0, evt_cyc = 0;
  bit   frame_open = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_reg_slave_if bus0 ();
  spi_reg_slave_if bus1 ();

  spi_reg_slave #(.AUTO_INC(1'b1)) dut_inc (.clk(clk), .rst(rst), .bus(bus0.slave));
  spi_reg_slave #(.AUTO_INC(1'b0)) dut_fix (.clk(clk), .rst(rst), .bus(bus1.slave));

  logic       we_v [2], re_v [2], busy_v [2], miso_v [2], done_v [2], err_v [2];
  logic [6:0] addr_v [2];
  logic [7:0] wdata_v [2], rdata_v [2];

  assign bus0.sck = sck;  assign bus0.ss = ss;  assign bus0.mosi = mosi;
  assign bus1.sck = sck;  assign bus1.ss = ss;  assign bus1.mosi = mosi;
  assign bus0.reg_rdata = rdata_v[0];
  assign bus1.reg_rdata = rdata_v[1];
  assign we_v[0] = bus0.reg_we;         assign we_v[1] = bus1.reg_we;
  assign re_v[0] = bus0.reg_re;         assign re_v[1] = bus1.reg_re;
  assign busy_v[0] = bus0.busy;         assign busy_v[1] = bus1.busy;
  assign miso_v[0] = bus0.miso;         assign miso_v[1] = bus1.miso;
  assign done_v[0] = bus0.frame_done;   assign done_v[1] = bus1.frame_done;
  assign err_v[0] = bus0.frame_err;     assign err_v[1] = bus1.frame_err;
  assign addr_v[0] = bus0.reg_addr;     assign addr_v[1] = bus1.reg_addr;
  assign wdata_v[0] = bus0.reg_wdata;   assign wdata_v[1] = bus1.reg_wdata;

  // Register bank behind each instance, one-clk registered read.
  logic [7:0] mem [2][128];
  always @(posedge clk)
    for (int k = 0; k < 2; k++)
      if (re_v[k]) rdata_v[k] <= mem[k][addr_v[k]];

  // Expected strobe lists: appended by stimulus, consumed by the compare process.
  logic [6:0] ew_addr [2][64];
  logic [7:0] ew_data [2][64];
  logic [6:0] er_addr [2][64];
  int ew_n [2] = '{0, 0};
  int ew_i [2] = '{0, 0};
  int er_n [2] = '{0, 0};
  int er_i [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  int err_cnt [2] = '{0, 0};
  logic [7:0] rx_log [8];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        if (we_v[k]) begin
          tests++;
          if (ew_i[k] >= ew_n[k]) begin
            fails++;
            $display("FAIL we_unexpected[%0d]: got write %02h<=%02h, required no write", k, addr_v[k], wdata_v[k]);
          end else begin
            if (addr_v[k] !== ew_addr[k][ew_i[k]] || wdata_v[k] !== ew_data[k][ew_i[k]]) begin
              fails++;
              $display("FAIL we_match[%0d]: got %02h<=%02h, required %02h<=%02h", k, addr_v[k], wdata_v[k],
                       ew_addr[k][ew_i[k]], ew_data[k][ew_i[k]]);
            end
            ew_i[k]++;
          end
        end
        if (re_v[k]) begin
          tests++;
          if (er_i[k] >= er_n[k]) begin
            fails++;
            $display("FAIL re_unexpected[%0d]: got read at %02h, required no read", k, addr_v[k]);
          end else begin
            if (addr_v[k] !== er_addr[k][er_i[k]]) begin
              fails++;
              $display("FAIL re_match[%0d]: got %02h, required %02h", k, addr_v[k], er_addr[k][er_i[k]]);
            end
            er_i[k]++;
          end
        end
        if (done_v[k]) done_cnt[k]++;
        if (err_v[k]) err_cnt[k]++;
        if (cyc - evt_cyc >= 5) begin
          tests++;
          if (busy_v[k] !== frame_open) begin
            fails++;
            $display("FAIL busy[%0d]: got %0b, required %0b", k, busy_v[k], frame_open);
          end
          if (!frame_open) begin
            tests++;
            if (miso_v[k] !== 1'b0) begin
              fails++;
              $display("FAIL miso_idle[%0d]: got %0b, required 0", k, miso_v[k]);
            end
          end
        end
      end
    end
  end

  task automatic check_eq(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h, required %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic logic [6:0] step(input int k, input logic [6:0] a);
    return (k == 0) ? a + 7'd1 : a;
  endfunction

  // Shift nbits of tx MSB first; the master samples miso on each rising edge.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, input bit ss_with_last,
                           output logic [7:0] rx0, output logic [7:0] rx1);
    rx0 = 8'h00;
    rx1 = 8'h00;
    for (int b = 7; b > 7 - nbits; b--) begin
      mosi = tx[b];
      repeat (H) @(negedge clk);
      sck = 1'b1;
      rx0[b] = bus0.miso;
      rx1[b] = bus1.miso;
      if (ss_with_last && b == 0) begin
        ss = 1'b1;
        frame_open = 1'b0;
        evt_cyc = cyc;
      end
      repeat (H) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input int nbytes, input logic [23:0] data,
                       input int tail_bits, input bit ss_with_last);
    logic [6:0] cur [2];
    logic [6:0] a;
    logic [7:0] r0, r1;
    int d0 [2], e0 [2];
    $display("[TB] frame cmd=%02h data=%06h bytes=%0d tail_bits=%0d ss_with_last=%0b",
             cmd, data, nbytes, tail_bits, ss_with_last);
    for (int k = 0; k < 2; k++) begin
      d0[k] = done_cnt[k];
      e0[k] = err_cnt[k];
      cur[k] = cmd[6:0];
      a = cmd[6:0];
      if (cmd[7]) begin
        er_addr[k][er_n[k]] = a;
        er_n[k]++;
        for (int i = 0; i < nbytes; i++) begin
          a = step(k, a);
          er_addr[k][er_n[k]] = a;
          er_n[k]++;
        end
      end else begin
        for (int i = 0; i < nbytes; i++) begin
          ew_addr[k][ew_n[k]] = a;
          ew_data[k][ew_n[k]] = data[23-8*i -: 8];
          ew_n[k]++;
          a = step(k, a);
        end
      end
    end
    ss = 1'b0;
    frame_open = 1'b1;
    evt_cyc = cyc;
    repeat (H) @(negedge clk);
    xfer_bits(cmd, 8, ss_with_last && nbytes == 0 && tail_bits == 0, r0, r1);
    rx_log[0] = r0;
    check_eq("cmd_miso_inc", r0, 8'h00);
    check_eq("cmd_miso_fix", r1, 8'h00);
    for (int i = 0; i < nbytes; i++) begin
      xfer_bits(data[23-8*i -: 8], 8, ss_with_last && i == nbytes - 1 && tail_bits == 0, r0, r1);
      rx_log[i+1] = r0;
      if (cmd[7]) begin
        check_eq("rd_byte_inc", r0, mem[0][cur[0]]);
        check_eq("rd_byte_fix", r1, mem[1][cur[1]]);
        cur[0] = step(0, cur[0]);
        cur[1] = step(1, cur[1]);
      end else begin
        check_eq("wr_miso_inc", r0, 8'h00);
        check_eq("wr_miso_fix", r1, 8'h00);
      end
    end
    if (tail_bits > 0)
      xfer_bits(data[23-8*nbytes -: 8], tail_bits, 1'b0, r0, r1);
    if (!ss_with_last) begin
      repeat (H) @(negedge clk);
      ss = 1'b1;
      frame_open = 1'b0;
      evt_cyc = cyc;
    end
    repeat (12) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_int("frame_done_cnt", done_cnt[k] - d0[k], (tail_bits == 0) ? 1 : 0);
      check_int("frame_err_cnt", err_cnt[k] - e0[k], (tail_bits == 0) ? 0 : 1);
    end
  endtask

  initial begin
    logic [7:0] r0, r1;
    int d0, e0;
    rst = 1'b1;
    sck = 1'b0;
    ss = 1'b1;
    mosi = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 128; i++)
        mem[k][i] = 8'h80 | 8'(i);
    for (int k = 0; k < 2; k++) begin
      mem[k][8'h12] = 8'hAA;
      mem[k][8'h40] = 8'h01;
      mem[k][8'h41] = 8'h02;
      mem[k][8'h42] = 8'h03;
    end

    // Reset state
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_miso", {7'd0, miso_v[k]}, 8'h00);
      check_eq("rst_addr", {1'b0, addr_v[k]}, 8'h00);
      check_eq("rst_wdata", wdata_v[k], 8'h00);
      check_eq("rst_we", {7'd0, we_v[k]}, 8'h00);
      check_eq("rst_re", {7'd0, re_v[k]}, 8'h00);
      check_eq("rst_busy", {7'd0, busy_v[k]}, 8'h00);
      check_eq("rst_done", {7'd0, done_v[k]}, 8'h00);
      check_eq("rst_err", {7'd0, err_v[k]}, 8'h00);
    end
    rst = 1'b0;
    evt_cyc = cyc;
    repeat (8) @(negedge clk);

    // sck activity with ss high must be ignored
    $display("[TB] idle sck toggling with ss high");
    d0 = done_cnt[0] + err_cnt[0];
    xfer_bits(8'h93, 8, 1'b0, r0, r1);
    xfer_bits(8'h05, 8, 1'b0, r0, r1);
    repeat (8) @(negedge clk);
    check_int("idle_no_status", done_cnt[0] + err_cnt[0], d0);
    check_eq("idle_miso_seen", r0, 8'h00);

    frame(8'h05, 1, 24'hA50000, 0, 1'b0);
    check_eq("single_wr_addr_lit", {1'b0, bus0.reg_addr}, 8'h05);
    check_eq("single_wr_data_lit", bus0.reg_wdata, 8'hA5);

    frame(8'h92, 1, 24'h000000, 0, 1'b0);
    check_eq("single_rd_cmd_lit", rx_log[0], 8'h00);
    check_eq("single_rd_data_lit", rx_log[1], 8'hAA);

    frame(8'h7E, 3, 24'h112233, 0, 1'b0);
    check_eq("burst_wr_wrap_addr_lit", {1'b0, bus0.reg_addr}, 8'h00);
    check_eq("burst_wr_wrap_data_lit", bus0.reg_wdata, 8'h33);
    check_eq("burst_wr_fixed_addr_lit", {1'b0, bus1.reg_addr}, 8'h7E);

    frame(8'hC0, 3, 24'h000000, 0, 1'b0);
    check_eq("burst_rd_b0_lit", rx_log[1], 8'h01);
    check_eq("burst_rd_b1_lit", rx_log[2], 8'h02);
    check_eq("burst_rd_b2_lit", rx_log[3], 8'h03);

    // Abort mid-byte, then a normal frame
    frame(8'h05, 0, 24'hFF0000, 3, 1'b0);
    frame(8'h06, 1, 24'h3C0000, 0, 1'b0);

    // ss rise detected together with the 8th sck rise
    frame(8'h20, 1, 24'h5A0000, 0, 1'b1);
    repeat (8) @(negedge clk);

    // Reset after the command byte with ss held low
    $display("[TB] reset mid-frame after cmd 05");
    d0 = done_cnt[0] + done_cnt[1];
    e0 = err_cnt[0] + err_cnt[1];
    ss = 1'b0;
    frame_open = 1'b1;
    evt_cyc = cyc;
    repeat (H) @(negedge clk);
    xfer_bits(8'h05, 8, 1'b0, r0, r1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    frame_open = 1'b0;
    evt_cyc = cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    evt_cyc = cyc;
    xfer_bits(8'hA5, 8, 1'b0, r0, r1);
    repeat (H) @(negedge clk);
    ss = 1'b1;
    evt_cyc = cyc;
    repeat (12) @(negedge clk);
    check_int("rst_abort_done", done_cnt[0] + done_cnt[1], d0);
    check_int("rst_abort_err", err_cnt[0] + err_cnt[1], e0);
    frame(8'h07, 1, 24'hC30000, 0, 1'b0);
    check_eq("post_rst_wr_addr_lit", {1'b0, bus0.reg_addr}, 8'h07);
    check_eq("post_rst_wr_data_lit", bus1.reg_wdata, 8'hC3);

    repeat (10) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_int("all_writes_seen", ew_i[k], ew_n[k]);
      check_int("all_reads_seen", er_i[k], er_n[k]);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/spi_reg_slave.md
# spi_reg_slave

SPI responder that exposes an 8-bit register bank to an SPI master over the standard four-wire link (sck, ss, mosi, miso). It decodes a command byte (read/write + 7-bit address) and then streams data bytes to or from a local register port, with address auto-increment for bursts. It sits on the slave side of the board-level SPI bus, behind the external MISO multiplexer, and is the register-access endpoint for the existing SPI master.

## Interface

- AUTO_INC, default 1: 1 = address increments after each data byte in a frame; 0 = address fixed for the whole frame.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- sck  in  1  SPI clock from master, asynchronous to clk, mode 0 (CPOL=0, CPHA=0).
- ss  in  1  slave select, active low, asynchronous.
- mosi  in  1  master out, slave in; MSB first.
- miso  out  1  slave out, master in; driven 0 whenever not in a read data byte, never tristated.
- reg_addr  out  7  register port address.
- reg_wdata  out  8  write data, valid with reg_we.
- reg_we  out  1  one-clk write strobe.
- reg_re  out  1  one-clk read request; reg_rdata sampled exactly one clk later.
- reg_rdata  in  8  read data (1-cycle registered-read latency).
- busy  out  1  high while a frame is open (ss low, synchronized).
- frame_done  out  1  one-clk pulse when ss deasserts after a frame with no partial byte.
- frame_err  out  1  one-clk pulse when ss deasserts mid-byte (bit count != 0).

## Operation

- sck, ss, mosi each pass through 2-flop synchronizers; edges are detected on synchronized sck/ss against a third registered copy.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE: ignore sck. Detected ss falling edge -> CMD, bit_cnt=0, busy=1.
- CMD: shift mosi into rx_shift on each detected sck rising edge. On the 8th edge (bit_cnt wraps 7->0): addr=rx[6:0]; rx[7]=1 -> RDATA and assert reg_re with that addr next clk; rx[7]=0 -> WDATA.
- WDATA: on the 8th rising edge of each byte, next clk assert reg_we with reg_addr=addr, reg_wdata=byte; then addr+=1 if AUTO_INC (modulo 128, 0x7F wraps to 0x00).
- RDATA: reg_rdata captured into tx_shift one clk after reg_re. miso=tx_shift[7]. tx_shift shifts left on detected sck falling edges while bit_cnt is 1..7; the falling edge at bit_cnt=0 does not shift. On the 8th rising edge of each data byte: addr+=1 if AUTO_INC, issue reg_re for new addr (prefetch), reload tx_shift. Prefetch past the last byte is harmless.
- mosi bits received during RDATA are ignored.
- Detected ss rising edge in any non-IDLE state -> IDLE, busy=0, miso=0; frame_done if bit_cnt==0, else frame_err. A partial write byte is discarded; no reg_we.
- ss rising and 8th sck rising edge detected in the same clk: complete the byte (reg_we/reg_re issue), then frame_done.

## Timing

- Pin-to-detect latency: 3 clk (2 sync + edge register).
- reg_we/reg_re: 1 clk after the detecting clk. tx_shift loaded 2 clk after detection.
- Requirement on master: sck high and low phases each >= 4 clk, so the reload completes before the next detected falling edge. ss setup to first sck rise and hold after last sck fall >= 4 clk.
- Reset values: miso=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, frame_done=0, frame_err=0. State=IDLE, bit_cnt=0.
- Reset asserted mid-frame: return to IDLE with no further strobes. With ss still low, stay in IDLE until a new ss falling edge; no frame_done or frame_err for the aborted frame.

## Test plan

- Single write: ss low, bytes 0x05, 0xA5, ss high -> exactly one reg_we with addr 0x05, wdata 0xA5; frame_done once; busy high only for the frame.
- Single read: model mem[0x12]=0xAA; bytes 0x92, 0x00 -> reg_re at addr 0x12; master receives 0xAA on byte 2 and 0x00 on byte 1.
- Burst write with wrap, AUTO_INC=1: cmd 0x7E then 0x11, 0x22, 0x33 -> reg_we at 0x7E/0x11, 0x7F/0x22, 0x00/0x33. With AUTO_INC=0: all three writes at 0x7E.
- Burst read: mem[0x40..0x42]=0x01,0x02,0x03; cmd 0xC0 + 3 bytes -> master receives 0x01, 0x02, 0x03.
- Abort: cmd 0x05, then 3 sck bits of data, ss high -> no reg_we, frame_err pulse, no frame_done; the next full write frame works normally.
- Idle/reset: toggle sck with ss high -> no strobes, miso=0. Assert rst after the command byte with ss low -> no strobes. After rst release, a fresh ss fall starts a frame that behaves normally.
